booth_radix4_seq_mult: RTL

- Parametrised, multi-cycle radix-4 Booth multiplier with valid/ready handshakes on input and output.
- Successor to the combinational radix-2 Booth array: it adds a per-transaction signed/unsigned mode and retires two multiplier bits per clock.
- It is a datapath leaf block, fed by an upstream operand source and drained by a consumer that may stall.

---
 rtl/booth_radix4_seq_mult.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/booth_radix4_seq_mult.sv
// booth_radix4_seq_mult
// Multi-cycle radix-4 Booth multiplier with valid/ready handshakes.
// Each transaction latches m, q and signed_mode. The block then retires two
// multiplier bits per clock over ITER steps and presents the product until
// the consumer takes it.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   in_valid     operands m, q, signed_mode are valid
//   in_ready     block can accept operands (IDLE and not in reset)
//   m, q         multiplicand / multiplier, WIDTH bits
//   signed_mode  1 = two's complement operands, 0 = unsigned operands
//   out_valid    product is valid (DONE)
//   out_ready    consumer accepts the product
//   product      2*WIDTH-bit result, held while out_valid && !out_ready
//   busy         high in CALC or DONE
module booth_radix4_seq_mult #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     m,
    input  logic [WIDTH-1:0]     q,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int ITER = WIDTH / 2 + 1;
    localparam int MW   = WIDTH + 2;   // extended operand width
    localparam int AW   = WIDTH + 4;   // accumulator width, headroom for 2M
    localparam int QW   = WIDTH + 3;   // extended multiplier plus q[-1]
    localparam int SW   = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [MW-1:0]         r_m;
    logic [AW-1:0]         r_acc;
    logic [QW-1:0]         r_q;
    logic [SW-1:0]         r_step;
    logic [2*WIDTH-1:0]    r_product;

    logic [AW-1:0]         w_sum;
    logic [AW-1:0]         w_acc_next;
    logic [QW-1:0]         w_q_next;
    logic [2*WIDTH-1:0]    w_result;
    logic                  w_last_step;
    logic [MW-1:0]         w_m_ext;
    logic [MW-1:0]         w_q_ext;

    // Booth recoding of one triplet into a sign-extended addend of 0, +-M, +-2M.
    function automatic logic [AW-1:0] booth_addend(input logic [2:0] trip,
                                                   input logic [MW-1:0] mx);
        logic [AW-1:0] m1;
        logic [AW-1:0] m2;
        m1 = {{2{mx[MW-1]}}, mx};
        m2 = {mx[MW-1], mx, 1'b0};
        case (trip)
            3'b001, 3'b010: booth_addend = m1;
            3'b011:         booth_addend = m2;
            3'b100:         booth_addend = (~m2) + {{(AW-1){1'b0}}, 1'b1};
            3'b101, 3'b110: booth_addend = (~m1) + {{(AW-1){1'b0}}, 1'b1};
            default:        booth_addend = {AW{1'b0}};
        endcase
    endfunction

    // Operand extension chosen by the mode presented at the accept edge.
    assign w_m_ext = signed_mode ? {{2{m[WIDTH-1]}}, m} : {2'b00, m};
    assign w_q_ext = signed_mode ? {{2{q[WIDTH-1]}}, q} : {2'b00, q};

    // One Booth step: add, then shift {acc, q} arithmetically right by two.
    assign w_sum       = r_acc + booth_addend(r_q[2:0], r_m);
    assign w_acc_next  = {{2{w_sum[AW-1]}}, w_sum[AW-1:2]};
    assign w_q_next    = {w_sum[1:0], r_q[QW-1:2]};
    assign w_last_step = (r_step == SW'(ITER - 1));
    // After 2*ITER shifts the product's low WIDTH+2 bits sit in r_q above q[-1].
    assign w_result    = {w_acc_next[WIDTH-3:0], w_q_next[QW-1:1]};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_next_state = S_CALC;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_CALC: begin
                if (w_last_step) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_CALC;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_DONE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath: operand latch, Booth iteration and product capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m       <= {MW{1'b0}};
            r_acc     <= {AW{1'b0}};
            r_q       <= {QW{1'b0}};
            r_step    <= {SW{1'b0}};
            r_product <= {(2*WIDTH){1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_m    <= w_m_ext;
                        r_q    <= {w_q_ext, 1'b0};
                        r_acc  <= {AW{1'b0}};
                        r_step <= {SW{1'b0}};
                    end
                end
                S_CALC: begin
                    r_acc  <= w_acc_next;
                    r_q    <= w_q_next;
                    r_step <= r_step + {{(SW-1){1'b0}}, 1'b1};
                    if (w_last_step) begin
                        r_product <= w_result;
                    end
                end
                default: begin
                    r_step <= r_step;
                end
            endcase
        end
    end

    // Status decodes come straight from the state register, so a reset clears
    // out_valid and busy without waiting for a clock edge.
    assign in_ready  = (r_state == S_IDLE) && !rst;
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign product   = r_product;

endmodule
